// File: rtl/bp_aes_subbytes_seq.sv
// bp_aes_subbytes_seq: sequential AES SubBytes/InvSubBytes over LANES shared S-boxes.
// bp_aes_sbox shares one GF(2^8) inverter between the forward and inverse paths.
module bp_aes_sbox (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = p ^ (b[k] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  logic [7:0] pre, x2, x3, x6, x12, x15, x240, x252, x254;

  // inverse undoes the affine map first, forward applies it after inversion
  assign pre  = inv ? rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05 : din;
  assign x2   = gmul(pre, pre);
  assign x3   = gmul(x2, pre);
  assign x6   = gmul(x3, x3);
  assign x12  = gmul(x6, x6);
  assign x15  = gmul(x12, x3);
  assign x240 = gmul(gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15))),
                     gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15))));
  assign x252 = gmul(x240, x12);
  assign x254 = gmul(x252, x2);
  assign dout = inv ? x254 : x254 ^ rotl(x254, 1) ^ rotl(x254, 2) ^ rotl(x254, 3) ^ rotl(x254, 4) ^ 8'h63;
endmodule

module bp_aes_subbytes_seq #(
  parameter int LANES = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_inv,
  input  logic [127:0] req_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_inv,
  output logic [127:0] rsp_data,
  output logic         busy
);
  localparam int N  = 16 / LANES;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int W  = 8 * LANES;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [127:0]  state_q;
  logic          inv_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    base;
  logic [W-1:0]  lane_in, lane_out;
  logic          last;

  assign base    = 8'(idx_q) * 8'(W);
  assign lane_in = state_q[base +: W];
  assign last    = idx_q == IW'(N - 1);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bp_aes_sbox u_sbox (.din(lane_in[8*i +: 8]), .inv(inv_q), .dout(lane_out[8*i +: 8]));
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    fsm_d = req_valid ? RUN : IDLE;
      RUN:     fsm_d = last ? DONE : RUN;
      DONE:    fsm_d = rsp_ready ? IDLE : DONE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      inv_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      fsm_q <= fsm_d;
      if (fsm_q == IDLE && req_valid) begin
        state_q <= req_data;
        inv_q   <= req_inv;
        idx_q   <= '0;
      end else if (fsm_q == RUN) begin
        state_q[base +: W] <= lane_out;
        idx_q              <= last ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign req_ready = fsm_q == IDLE;
  assign rsp_valid = fsm_q == DONE;
  assign busy      = fsm_q != IDLE;
  assign rsp_data  = state_q;
  assign rsp_inv   = inv_q;
endmodule

// File: tb/tb_bp_aes_subbytes_seq.sv
// tb_bp_aes_subbytes_seq: directed and LANES-sweep checks of the sequential SubBytes engine.
module tb_bp_aes_subbytes_seq;
  localparam logic [7:0] FWD [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         req_valid = 1'b0, req_inv = 1'b0, rsp_ready = 1'b0;
  logic [127:0] req_data = '0;
  logic         req_ready, rsp_valid, rsp_inv, busy;
  logic [127:0] rsp_data;

  logic         sw_valid = 1'b0, sw_inv = 1'b0, sw_ready = 1'b1;
  logic [127:0] sw_data = '0;
  logic         sw_req_ready [5], sw_rsp_valid [5], sw_rsp_inv [5], sw_busy [5];
  logic [127:0] sw_rsp_data [5];

  logic [7:0] inv_tab [256];
  int checks = 0, errors = 0, cyc = 0;
  int last_acc [5] = '{-1, -1, -1, -1, -1};
  int ivl [5] = '{0, 0, 0, 0, 0};

  always #5 clock = ~clock;

  bp_aes_subbytes_seq #(.LANES(1)) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready), .req_inv(req_inv),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inv(rsp_inv),
    .rsp_data(rsp_data), .busy(busy));

  for (genvar g = 0; g < 5; g++) begin : g_sw
    bp_aes_subbytes_seq #(.LANES(1 << g)) u_sw (
      .clock(clock), .resetn(resetn), .req_valid(sw_valid), .req_ready(sw_req_ready[g]), .req_inv(sw_inv),
      .req_data(sw_data), .rsp_valid(sw_rsp_valid[g]), .rsp_ready(sw_ready), .rsp_inv(sw_rsp_inv[g]),
      .rsp_data(sw_rsp_data[g]), .busy(sw_busy[g]));
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 5; g++)
      if (sw_valid && sw_req_ready[g]) begin
        if (last_acc[g] >= 0) ivl[g] <= cyc - last_acc[g];
        last_acc[g] <= cyc;
      end
  end

  function automatic logic [127:0] sub_state(input logic [127:0] d, input logic v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = v ? inv_tab[d[8*k +: 8]] : FWD[d[8*k +: 8]];
    return r;
  endfunction

  task automatic start_req(input logic [127:0] d, input logic v);
    @(negedge clock); req_valid = 1'b1; req_data = d; req_inv = v;
    @(posedge clock);
    @(negedge clock); req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(negedge clock); lat++; end
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock); rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_async: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); end
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); end
    checks++; if (rsp_data !== 128'h0 || rsp_inv !== 1'b0) begin errors++; $display("FAIL reset_data: got %h/%b want 0/0", rsp_data, rsp_inv); end
  endtask

  task automatic test_forward_zero;
    int lat;
    start_req(128'h0, 1'b0);
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL fz_run: busy=%b req_ready=%b want 1 0", busy, req_ready); end
    wait_rsp(lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL fz_latency: got %0d want 16", lat); end
    checks++; if (rsp_data !== {16{8'h63}}) begin errors++; $display("FAIL fz_data: got %h want %h", rsp_data, {16{8'h63}}); end
    checks++; if (rsp_inv !== 1'b0) begin errors++; $display("FAIL fz_inv: got %b want 0", rsp_inv); end
    finish_rsp();
  endtask

  task automatic test_inverse;
    int lat;
    start_req({16{8'h63}}, 1'b1); wait_rsp(lat);
    checks++; if (rsp_data !== 128'h0 || rsp_inv !== 1'b1) begin errors++; $display("FAIL inv_63: got %h/%b want 0/1", rsp_data, rsp_inv); end
    finish_rsp();
    start_req(128'h0f0e0d0c0b0a09080706050403020100, 1'b0); wait_rsp(lat);
    checks++; if (rsp_data !== 128'h76abd7fe2b670130c56f6bf27b777c63) begin errors++; $display("FAIL fwd_ramp: got %h want 76abd7fe2b670130c56f6bf27b777c63", rsp_data); end
    finish_rsp();
    start_req(128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1); wait_rsp(lat);
    checks++; if (rsp_data !== 128'h0f0e0d0c0b0a09080706050403020100) begin errors++; $display("FAIL inv_ramp: got %h want 0f0e0d0c0b0a09080706050403020100", rsp_data); end
    finish_rsp();
    start_req(128'h53, 1'b0); wait_rsp(lat);
    checks++; if (rsp_data !== {{15{8'h63}}, 8'hed}) begin errors++; $display("FAIL fwd_53: got %h want %h", rsp_data, {{15{8'h63}}, 8'hed}); end
    finish_rsp();
  endtask

  task automatic test_backpressure;
    int lat;
    logic [127:0] exp_d;
    exp_d = sub_state(128'h00112233445566778899aabbccddeeff, 1'b1);
    start_req(128'h00112233445566778899aabbccddeeff, 1'b1); wait_rsp(lat);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_inv !== 1'b1 || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold c%0d: v=%b d=%h i=%b rdy=%b want 1 %h 1 0", c, rsp_valid, rsp_data, rsp_inv, req_ready, exp_d);
      end
      @(negedge clock);
    end
    finish_rsp();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: rdy=%b v=%b busy=%b want 1 0 0", req_ready, rsp_valid, busy); end
  endtask

  task automatic test_reset_mid_run;
    int stray = 0;
    start_req(128'hdeadbeef0123456789abcdeffedcba98, 1'b0);
    repeat (7) @(negedge clock);
    #1 resetn = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 128'h0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: v=%b busy=%b d=%h rdy=%b want 0 0 0 1", rsp_valid, busy, rsp_data, req_ready);
    end
    @(negedge clock); resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin @(negedge clock); if (rsp_valid || !req_ready) stray++; end
    checks++; if (stray !== 0) begin errors++; $display("FAIL mid_reset_stray: got %0d bad cycles want 0", stray); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [127:0] a, b;
    a = 128'h000102030405060708090a0b0c0d0e0f;
    b = 128'hffeeddccbbaa99887766554433221100;
    @(negedge clock); req_valid = 1'b1; req_data = a; req_inv = 1'b0;
    @(posedge clock);
    @(negedge clock); req_data = b; req_inv = 1'b1;
    wait_rsp(lat);
    checks++; if (lat !== 16 || rsp_data !== sub_state(a, 1'b0) || rsp_inv !== 1'b0) begin
      errors++; $display("FAIL b2b_first: lat=%0d d=%h i=%b want 16 %h 0", lat, rsp_data, rsp_inv, sub_state(a, 1'b0));
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock); rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: rdy=%b v=%b want 1 0", req_ready, rsp_valid); end
    @(posedge clock);
    @(negedge clock); req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b want 1", busy); end
    wait_rsp(lat);
    checks++; if (lat !== 16 || rsp_data !== sub_state(b, 1'b1) || rsp_inv !== 1'b1) begin
      errors++; $display("FAIL b2b_second: lat=%0d d=%h i=%b want 16 %h 1", lat, rsp_data, rsp_inv, sub_state(b, 1'b1));
    end
    finish_rsp();
  endtask

  task automatic test_sweep;
    for (int t = 0; t < 4; t++) begin
      logic [127:0] d;
      logic v;
      d = {$urandom, $urandom, $urandom, $urandom};
      v = 1'($urandom_range(0, 1));
      @(negedge clock); sw_valid = 1'b1; sw_inv = v; sw_data = d;
      @(posedge clock);
      @(negedge clock); sw_valid = 1'b0;
      for (int k = 1; k <= 17; k++) begin
        @(negedge clock);
        for (int g = 0; g < 5; g++) begin
          checks++;
          if (sw_rsp_valid[g] !== (k == (16 >> g))) begin errors++; $display("FAIL sweep_valid L%0d k%0d: got %b want %b", 1 << g, k, sw_rsp_valid[g], k == (16 >> g)); end
          if (k == (16 >> g)) begin
            checks++;
            if (sw_rsp_data[g] !== sub_state(d, v) || sw_rsp_inv[g] !== v) begin
              errors++; $display("FAIL sweep_data L%0d: got %h/%b want %h/%b", 1 << g, sw_rsp_data[g], sw_rsp_inv[g], sub_state(d, v), v);
            end
          end
        end
      end
    end
  endtask

  task automatic test_throughput;
    @(negedge clock); sw_valid = 1'b1; sw_inv = 1'b0; sw_data = 128'h0123456789abcdef0123456789abcdef;
    repeat (60) @(negedge clock);
    sw_valid = 1'b0;
    repeat (20) @(negedge clock);
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (ivl[g] !== (16 >> g) + 2) begin errors++; $display("FAIL throughput L%0d: got %0d want %0d", 1 << g, ivl[g], (16 >> g) + 2); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) inv_tab[FWD[i]] = 8'(i);
    test_reset();
    test_forward_zero();
    test_inverse();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep();
    test_throughput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
